// File: rtl/csr_pkg.sv
// Shared CSR definitions: modify codes, peripheral addresses, status layout and RX FSM states.
package csr_pkg;

    localparam logic [2:0] CSR_MOD_NONE  = 3'd0;
    localparam logic [2:0] CSR_MOD_WRITE = 3'd1;
    localparam logic [2:0] CSR_MOD_SET   = 3'd2;
    localparam logic [2:0] CSR_MOD_CLEAR = 3'd3;

    localparam logic [11:0] CSR_UART_RX_ADDR = 12'hBC0;
    localparam logic [31:0] RX_EMPTY         = 32'hFFFF_FFFF;

    localparam int ST_NONEMPTY  = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_FRAMING   = 2;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/csr_uart_rx_fifo.sv
// Synchronous FIFO; a pop frees space for a push in the same cycle, even when full.
module sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int FIFO_LOG = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                push,
    input  logic                pop,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    head,
    output logic                full,
    output logic                empty,
    output logic [FIFO_LOG:0]   count
);

    localparam int DEPTH = 1 << FIFO_LOG;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [FIFO_LOG-1:0] wr_ptr;
    logic [FIFO_LOG-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (FIFO_LOG + 1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/csr_uart_rx.sv
// CSR-mapped 8N1 UART receiver with byte FIFO, overrun/framing flags and non-empty interrupt.
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronized line
//   START | timing to the middle of the start bit, rejecting glitches
//   DATA  | sampling 8 data bits LSB first at bit centres
//   STOP  | sampling the stop bit; push the byte or flag a framing error
module csr_uart_rx
    import csr_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR = CSR_UART_RX_ADDR,
    parameter int          DIVISOR   = 16,
    parameter int          FIFO_LOG  = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        irq
);

    localparam logic [15:0] HALF_LOAD = 16'(DIVISOR / 2 - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(DIVISOR - 1);

    logic              rx_s1;
    logic              rxs;
    logic              rxs_prev;
    rx_state_t         state;
    logic [15:0]       cnt;
    logic [2:0]        idx;
    logic [7:0]        shreg;
    logic              push_q;
    logic              frame_err_q;
    logic              read_q;
    logic [11:0]       addr_q;
    logic              overrun;
    logic              framing;

    logic [7:0]        head;
    logic              full;
    logic              empty;
    logic [FIFO_LOG:0] count;

    logic              hit_data;
    logic              hit_stat;
    logic              pop;
    logic              clr_wr;
    logic              ovr_set;
    logic [31:0]       status_word;
    logic              unused_wdata;

    assign hit_data     = (addr_q == BASE_ADDR);
    assign hit_stat     = (addr_q == BASE_ADDR + 12'd1);
    assign valid        = read_q & (hit_data | hit_stat);
    assign pop          = read_q & hit_data & ~empty;
    assign clr_wr       = hit_stat & (modify != CSR_MOD_NONE);
    assign ovr_set      = push_q & full & ~pop;
    assign unused_wdata = ^{wdata[31:3], wdata[0]};

    always_comb begin
        status_word                                  = '0;
        status_word[ST_NONEMPTY]                     = ~empty;
        status_word[ST_OVERRUN]                      = overrun;
        status_word[ST_FRAMING]                      = framing;
        status_word[ST_COUNT_LSB+FIFO_LOG:ST_COUNT_LSB] = count;
    end

    always_comb begin
        rdata = '0;
        if (valid) begin
            if (hit_data) begin
                rdata = empty ? RX_EMPTY : {24'b0, head};
            end else begin
                rdata = status_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
            read_q   <= 1'b0;
            addr_q   <= '0;
            irq      <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rxs      <= rx_s1;
            rxs_prev <= rxs;
            read_q   <= read;
            addr_q   <= addr;
            irq      <= ~empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxs_prev & ~rxs) begin
                        cnt   <= HALF_LOAD;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rxs) begin
                        cnt   <= BIT_LOAD;
                        idx   <= '0;
                        state <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg[idx] <= rxs;
                        cnt        <= BIT_LOAD;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        push_q      <= rxs;
                        frame_err_q <= ~rxs;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A flag event in the same cycle as a write-1-to-clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            overrun <= 1'b0;
            framing <= 1'b0;
        end else begin
            overrun <= ovr_set | (overrun & ~(clr_wr & wdata[ST_OVERRUN]));
            framing <= frame_err_q | (framing & ~(clr_wr & wdata[ST_FRAMING]));
        end
    end

    sync_fifo #(
        .WIDTH    (8),
        .FIFO_LOG (FIFO_LOG)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push_q),
        .pop   (pop),
        .wdata (shreg),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_csr_uart_rx.sv
// Scoreboard bench for csr_uart_rx: reads queue their expected data, a negedge monitor checks each claimed access.
module tb_csr_uart_rx;

    localparam logic [11:0] BASE  = 12'hBC0;
    localparam logic [11:0] STAT  = 12'hBC1;
    localparam int          DIV   = 16;
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;

    logic        clk    = 1'b0;
    logic        rstn   = 1'b0;
    logic        read   = 1'b0;
    logic [2:0]  modify = 3'd0;
    logic [31:0] wdata  = '0;
    logic [11:0] addr   = '0;
    logic        rx     = 1'b1;
    logic [31:0] rdata;
    logic        valid;
    logic        irq;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    csr_uart_rx dut (
        .clk    (clk),
        .rstn   (rstn),
        .read   (read),
        .modify (modify),
        .wdata  (wdata),
        .addr   (addr),
        .rdata  (rdata),
        .valid  (valid),
        .rx     (rx),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: rdata %h with no read outstanding", rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.nm, rdata, e.v);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(DIV);
        end
        rx = stop_bit;
        idle(DIV);
        rx = 1'b1;
    endtask

    task automatic csr_read(input logic [11:0] a, input logic [31:0] exp, input string nm);
        exp_t e;
        e.nm = nm;
        e.v  = exp;
        sb.push_back(e);
        read = 1'b1;
        addr = a;
        idle(1);
        read = 1'b0;
        idle(2);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [2:0] m, input logic [31:0] w);
        addr = a;
        idle(1);
        modify = m;
        wdata  = w;
        idle(1);
        modify = 3'd0;
        wdata  = '0;
        idle(1);
    endtask

    initial begin
        idle(3);
        check("reset_irq", {31'b0, irq}, 32'd0);
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rstn = 1'b1;
        idle(2);

        read = 1'b1;
        addr = 12'hBC2;
        idle(1);
        read = 1'b0;
        check("unclaimed_valid", {31'b0, valid}, 32'd0);
        check("unclaimed_rdata", rdata, 32'd0);
        idle(2);
        csr_read(STAT, 32'd0, "stat_init");

        // single byte
        send_frame(8'h55, 1'b1);
        check("single_irq_set", {31'b0, irq}, 32'd1);
        csr_read(BASE, 32'h55, "single_data");
        csr_read(BASE, EMPTY, "single_empty");
        idle(2);
        check("single_irq_clr", {31'b0, irq}, 32'd0);

        // overrun
        for (int b = 1; b <= 9; b++) begin
            send_frame(8'(b), 1'b1);
        end
        csr_read(STAT, 32'h0000_0803, "ovr_status");
        for (int b = 1; b <= 8; b++) begin
            csr_read(BASE, 32'(b), "ovr_data");
        end
        csr_read(BASE, EMPTY, "ovr_empty");
        csr_read(STAT, 32'h0000_0002, "ovr_sticky");
        csr_write(STAT, 3'd1, 32'h2);
        csr_read(STAT, 32'd0, "ovr_cleared");

        // framing error
        send_frame(8'hA5, 1'b0);
        idle(4);
        csr_read(STAT, 32'h0000_0004, "frm_status");
        csr_write(BASE, 3'd1, 32'hFFFF_FFFF);
        csr_read(STAT, 32'h0000_0004, "frm_data_write_ignored");
        csr_write(STAT, 3'd1, 32'h4);
        csr_read(STAT, 32'd0, "frm_cleared");

        // glitch
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        csr_read(STAT, 32'd0, "glitch_status");
        check("glitch_irq", {31'b0, irq}, 32'd0);

        // pop lands in the push cycle of a full FIFO
        for (int b = 16; b < 24; b++) begin
            send_frame(8'(b), 1'b1);
        end
        fork
            send_frame(8'h18, 1'b1);
            begin
                exp_t e;
                repeat (154) @(posedge clk);
                #1;
                e.nm = "simul_pop";
                e.v  = 32'h10;
                sb.push_back(e);
                read = 1'b1;
                addr = BASE;
                @(posedge clk);
                #1;
                read = 1'b0;
            end
        join
        idle(2);
        csr_read(STAT, 32'h0000_0801, "simul_status");
        for (int b = 17; b <= 24; b++) begin
            csr_read(BASE, 32'(b), "simul_data");
        end
        csr_read(BASE, EMPTY, "simul_empty");

        // reset during data bit 3
        fork
            send_frame(8'hF8, 1'b1);
            begin
                repeat (70) @(posedge clk);
                #1;
                rstn = 1'b0;
                @(posedge clk);
                #1;
                rstn = 1'b1;
            end
        join
        idle(4);
        check("rst_irq", {31'b0, irq}, 32'd0);
        csr_read(STAT, 32'd0, "rst_status");
        send_frame(8'h3C, 1'b1);
        csr_read(BASE, 32'h3C, "rst_next_frame");
        csr_read(BASE, EMPTY, "rst_empty");

        idle(4);
        check("pending_reads", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
